avr109rx: RTL and testbench
===========================

// Module: avr109rx
// PURPOSE
//  UART receive half of the AVR109 bootloader serial link; pairs with the transmit half.
//  Format is 8N1: start bit low, 8 data bits LSB first, one stop bit high, idle high.
//  Samples asynchronous rxd at mid-bit using a clk-derived baud counter.
//  Presents each received byte with a one-cycle strobe to the command parser.
//  Flags framing errors (stop bit low, e.g. a line break).
// PARAMETERS
//  CLK_FREQUENCY  1000000  clk frequency in Hz
//  BAUD_RATE      19200    line rate in bit/s
//  (derived) BAUDDIV = CLK_FREQUENCY/BAUD_RATE (integer divide); HALFDIV = BAUDDIV/2
//  (derived) counter width = ceil(log2(BAUDDIV)), minimum 1
// PORTS
//  clk          in   1  clock
//  rst          in   1  reset, synchronous, active-high
//  rxd          in   1  serial input, asynchronous to clk, idle high
//  rx_data      out  8  last good received byte
//  rx_avail     out  1  one-cycle strobe: rx_data updated this cycle
//  framing_err  out  1  one-cycle strobe: stop bit sampled low
// BEHAVIOUR
//  - rxd passes a 2-FF synchronizer (both FFs reset to 1) to give rxd_s. All decisions use rxd_s only.
//  - Reset values: rx_data=8'h00, rx_avail=0, framing_err=0, state=IDLE, counters=0,
//    sync FFs=1. Reset mid-frame abandons the frame with no strobe.
//  - States:
//    IDLE: rxd_s==0 -> START, baud counter=0.
//    START: count up; at count==HALFDIV-1, sample rxd_s.
//      0 -> DATA, counter=0, bitcnt=0.
//      1 -> IDLE (glitch rejected, no strobe).
//    DATA: count up; at count==BAUDDIV-1, shift rxd_s into shreg MSB (LSB-first),
//      counter=0, bitcnt++. After the 8th bit -> STOP.
//    STOP: at count==BAUDDIV-1, sample rxd_s.
//      1 -> rx_data<=shreg, rx_avail=1 for exactly one cycle, -> IDLE.
//      0 -> framing_err=1 for one cycle, rx_data unchanged, -> BRK.
//    BRK: wait for rxd_s==1, then -> IDLE. A held-low line produces exactly one framing_err.
//  - Each sample lands mid-bit: the start bit is sampled after HALFDIV, every later bit after a
//    further BAUDDIV.
//  - rx_avail/framing_err rise on the clk edge after the stop-bit sample.
//  - rxd falling to rx_avail = 2 sync cycles + HALFDIV + 9*BAUDDIV + 1 cycles.
//  - rx_avail and framing_err are never high together.
//  - No backpressure: the consumer must take rx_data on the strobe. rx_data holds until the next
//    good byte, so a missed strobe is overwritten silently.
//  - Back-to-back frames: IDLE is entered mid-stop-bit, so a start edge that follows the stop bit
//    immediately is caught.
//  - Counters are compared with ==, never wrap in normal operation, and reset to 0 on each state
//    change.
// TESTING
//  (CLK_FREQUENCY=1000000, BAUD_RATE=19200 -> BAUDDIV=52, HALFDIV=26)
//  1. Reset, rxd=1 for 100 cycles -> rx_avail=0, framing_err=0, rx_data=8'h00.
//  2. Send 0x55, bit period 52 -> exactly one rx_avail pulse, rx_data=8'h55, at 2+26+468+1 cycles
//     after the falling edge.
//  3. Send 0xA5 then 0x3C back-to-back (no idle gap) -> two rx_avail pulses; rx_data 8'hA5 then
//     8'h3C; framing_err never high.
//  4. rxd low for 10 cycles then high -> no strobe, returns to IDLE; a following 0x81 is received
//     correctly.
//  5. Send 0xF0 with stop bit low, hold rxd low 300 cycles, release ->
//     one framing_err pulse, no rx_avail, rx_data unchanged; then 0x0F -> rx_avail with 8'h0F.
//  6. Assert rst during data bit 4 of a frame -> no strobe, outputs at reset values;
//     the next full 0x33 frame is received correctly.
//  7. Bit periods of 51 and 53 (+/-2%) with byte 0xC3 -> rx_data=8'hC3 in both cases.

Source files
------------

// File: rtl/avr109rx.sv
// avr109rx: 8N1 UART receiver for the AVR109 bootloader link.
// The asynchronous line is synchronised, the start bit is validated at
// mid-bit, then each data bit and the stop bit are sampled one baud period
// apart. Good bytes are presented with a one-cycle strobe; a low stop bit
// raises a one-cycle framing error and the receiver waits for the line to
// return high before hunting for the next start bit.
module avr109rx #(
    parameter int CLK_FREQUENCY = 1000000,
    parameter int BAUD_RATE     = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       framing_err
);

    localparam int BAUDDIV = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALFDIV = BAUDDIV / 2;
    localparam int CW      = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;

    // Terminal counts; counters are compared for equality and cleared on
    // every state change, so they never wrap in normal operation.
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUDDIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALFDIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rxd_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shreg_q;
    logic [7:0]    rx_data_q;
    logic          avail_q;
    logic          ferr_q;

    // Two-flop synchroniser; both stages reset to the idle (high) level so
    // reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rxd_s = sync2_q;

    // Receive state machine with registered strobes and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            rx_data_q <= 8'h00;
            avail_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            avail_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        // Mid start bit: a line already back high was a glitch.
                        cnt_q    <= '0;
                        bitcnt_q <= '0;
                        state_q  <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BAUD_LAST) begin
                        // LSB arrives first, so shift in from the top.
                        cnt_q    <= '0;
                        shreg_q  <= {rxd_s, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BAUD_LAST) begin
                        // Leaving at mid stop bit lets an immediately
                        // following start edge be caught from IDLE.
                        cnt_q <= '0;
                        if (rxd_s) begin
                            rx_data_q <= shreg_q;
                            avail_q   <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BRK: begin
                    // A held-low line reports only one framing error.
                    cnt_q <= '0;
                    if (rxd_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_avail    = avail_q;
    assign framing_err = ferr_q;

endmodule

// File: tb/tb_avr109rx.sv
// Testbench for avr109rx: directed frame table, hand-written corner cases
// and random frames checked against an event scoreboard.
module tb_avr109rx;

    localparam int LAT = 2 + 26 + 9 * 52 + 1;  // falling edge to strobe, in clk cycles

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       framing_err;

    avr109rx #(.CLK_FREQUENCY(1000000), .BAUD_RATE(19200)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_avail    (rx_avail),
        .framing_err (framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] drv_last = 8'h00;  // last good byte as the line model sees it

    typedef struct {
        logic [7:0] data;
        int         per;
        bit         stop_ok;
        int         low_hold;
        int         gap;
        bit         exp_avail;
        bit         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame starting at the current negedge and queue the
    // strobe the receiver must produce a fixed latency after the start edge.
    task automatic send_frame(input logic [7:0] d, input int per, input bit stop_ok,
                              input int low_hold, input bit e_avail, input bit e_err,
                              input logic [7:0] e_data);
        exp_t e;
        if (e_avail || e_err) begin
            e.cyc  = cyc + LAT;
            e.err  = e_err;
            e.data = e_data;
            q.push_back(e);
            if (e_avail) drv_last = e_data;
        end
        rxd = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (per) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (per) @(negedge clk);
        if (!stop_ok) repeat (low_hold) @(negedge clk);
        rxd = 1'b1;
    endtask

    // Scoreboard: every strobe must match the next expected event exactly.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_avail || framing_err) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_strobe: cyc=%0d avail=%0b ferr=%0b data=%02h, expected none",
                             cyc, rx_avail, framing_err, rx_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cyc != e.cyc || rx_avail !== !e.err || framing_err !== e.err || rx_data !== e.data) begin
                        fails++;
                        $display("[TB] FAIL strobe: cyc=%0d avail=%0b ferr=%0b data=%02h, expected cyc=%0d avail=%0b ferr=%0b data=%02h",
                                 cyc, rx_avail, framing_err, rx_data, e.cyc, !e.err, e.err, e.data);
                    end else begin
                        $display("[TB] rx cyc=%0d %s data=%02h ok", cyc, e.err ? "framing_err" : "rx_avail", rx_data);
                    end
                end
            end
            if (q.size() > 0 && cyc > q[0].cyc) begin
                exp_t m;
                m = q.pop_front();
                tests++;
                fails++;
                $display("[TB] FAIL missing_strobe: none by cyc=%0d, expected err=%0b data=%02h at cyc=%0d",
                         cyc, m.err, m.data, m.cyc);
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [7:0] d;
        int         per;
        bit         ok;

        vecs[0] = '{8'h55, 52, 1'b1, 0,   50, 1'b1, 1'b0, 8'h55};
        vecs[1] = '{8'hA5, 52, 1'b1, 0,   0,  1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 52, 1'b1, 0,   50, 1'b1, 1'b0, 8'h3C};
        vecs[3] = '{8'hF0, 52, 1'b0, 300, 50, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{8'h0F, 52, 1'b1, 0,   50, 1'b1, 1'b0, 8'h0F};
        vecs[5] = '{8'hC3, 51, 1'b1, 0,   50, 1'b1, 1'b0, 8'hC3};
        vecs[6] = '{8'hC3, 53, 1'b1, 0,   50, 1'b1, 1'b0, 8'hC3};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // Idle line after reset
        repeat (100) @(negedge clk);
        chk("reset_rx_avail", {31'd0, rx_avail}, 32'd0);
        chk("reset_framing_err", {31'd0, framing_err}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);

        // Directed frames: latency, back-to-back, framing error, baud skew
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].per, vecs[i].stop_ok, vecs[i].low_hold,
                       vecs[i].exp_avail, vecs[i].exp_err, vecs[i].exp_data);
            idle(vecs[i].gap);
        end
        chk("after_table_rx_data", {24'd0, rx_data}, 32'hC3);

        // Short low glitch is rejected, next frame still decodes
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        idle(60);
        send_frame(8'h81, 52, 1'b1, 0, 1'b1, 1'b0, 8'h81);
        idle(50);
        chk("glitch_then_rx_data", {24'd0, rx_data}, 32'h81);

        // Reset in the middle of data bit 4 abandons the frame
        d   = 8'h5A;
        rxd = 1'b0;
        repeat (52) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (52) @(negedge clk);
        end
        rxd = d[4];
        repeat (26) @(negedge clk);
        rst      = 1'b1;
        rxd      = 1'b1;
        drv_last = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("midreset_rx_avail", {31'd0, rx_avail}, 32'd0);
        chk("midreset_framing_err", {31'd0, framing_err}, 32'd0);
        chk("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        send_frame(8'h33, 52, 1'b1, 0, 1'b1, 1'b0, 8'h33);
        idle(50);
        chk("after_reset_rx_data", {24'd0, rx_data}, 32'h33);

        // Random frames: skewed baud, occasional low stop bit, random gaps
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            per = $urandom_range(51, 53);
            ok  = ($urandom_range(0, 7) != 0);
            send_frame(d, per, ok, $urandom_range(0, 100), ok, !ok, ok ? d : drv_last);
            idle(ok ? $urandom_range(0, 20) : $urandom_range(5, 20));
        end

        idle(600);
        chk("final_rx_data", {24'd0, rx_data}, {24'd0, drv_last});
        chk("pending_events", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
